// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller.
//   sar_state_t     : controller state encoding
//   NBIT_DEF        : default conversion resolution (bits)
//   SAMPLE_CYC_DEF  : default tracking-phase length (clk cycles)
//   TIMEOUT_DEF     : default comparator decision timeout (clk cycles)
package sar_pkg;

  localparam int NBIT_DEF       = 10;
  localparam int SAMPLE_CYC_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    COMPARE,
    RESOLVE,
    DONE
  } sar_state_t;

endpackage

// File: rtl/sar_logic_if.sv
// Signal bundle between the SAR controller and its analog front end.
//   soc          : start of conversion (into controller)
//   vop, von     : comparator decisions, asynchronous (into controller)
//   samp         : top-plate sampling switch, 1 = track
//   ckl          : comparator loop hold, 1 = held, 0 = compare
//   dacp, dacn   : capacitor-DAC switch controls, dacn == ~dacp
//   dout         : last completed conversion result
//   eoc          : one-cycle end-of-conversion pulse
//   busy         : controller not idle
//   to_flag      : sticky comparator-timeout indicator
// Modport slave is the controller view, master the front-end/stimulus view.
interface sar_logic_if
  import sar_pkg::*;
#(
  parameter int NBIT = NBIT_DEF
) ();

  logic            soc;
  logic            vop;
  logic            von;
  logic            samp;
  logic            ckl;
  logic [NBIT-1:0] dacp;
  logic [NBIT-1:0] dacn;
  logic [NBIT-1:0] dout;
  logic            eoc;
  logic            busy;
  logic            to_flag;

  modport slave (
    input  soc, vop, von,
    output samp, ckl, dacp, dacn, dout, eoc, busy, to_flag
  );

  modport master (
    output soc, vop, von,
    input  samp, ckl, dacp, dacn, dout, eoc, busy, to_flag
  );

endinterface

// File: rtl/sar_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
//   clk : destination clock
//   rst : synchronous reset, clears both stages
//   d   : asynchronous input
//   q   : synchronized output (2 cycles latency)
module sar_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation ADC controller.
// Ports:
//   clk : single clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : sar_logic_if.slave (soc, vop, von in; samp, ckl, dacp, dacn,
//         dout, eoc, busy, to_flag out)
// Optional build macro SAR_TIMEOUT_EN: a bit whose comparator gives no
// decision within TIMEOUT cycles resolves to 0 and sets the sticky
// to_flag. Without it, COMPARE waits indefinitely and to_flag is 0.
module sar_logic
  import sar_pkg::*;
#(
  parameter int NBIT       = NBIT_DEF,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  sar_logic_if.slave  bus
);

  localparam int         IW        = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam logic [7:0] SAMP_LAST = 8'(SAMPLE_CYC - 1);

  if (SAMPLE_CYC < 1 || SAMPLE_CYC > 255) begin : g_bad_sample_cyc
    $error("sar_logic: SAMPLE_CYC must be within 1..255");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sar_logic: TIMEOUT must be within 2..255");
  end

  logic vop_s;
  logic von_s;

  sar_sync2 u_sync_vop (.clk(clk), .rst(rst), .d(bus.vop), .q(vop_s));
  sar_sync2 u_sync_von (.clk(clk), .rst(rst), .d(bus.von), .q(von_s));

  sar_state_t      state_reg;
  logic [NBIT-1:0] code_reg;
  logic [IW-1:0]   idx_reg;
  logic [7:0]      cnt_reg;
  logic            samp_reg;
  logic            ckl_reg;
  logic [NBIT-1:0] dout_reg;
  logic            eoc_reg;

`ifdef SAR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt_reg;
  logic       to_flag_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      code_reg  <= '0;
      idx_reg   <= IW'(NBIT - 1);
      cnt_reg   <= '0;
      samp_reg  <= 1'b0;
      ckl_reg   <= 1'b1;
      dout_reg  <= '0;
      eoc_reg   <= 1'b0;
`ifdef SAR_TIMEOUT_EN
      to_cnt_reg  <= '0;
      to_flag_reg <= 1'b0;
`endif
    end else begin
      eoc_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.soc) begin
            state_reg <= SAMPLE;
            code_reg  <= '0;
            idx_reg   <= IW'(NBIT - 1);
            cnt_reg   <= '0;
            samp_reg  <= 1'b1;
            ckl_reg   <= 1'b1;
`ifdef SAR_TIMEOUT_EN
            to_flag_reg <= 1'b0;
`endif
          end
        end
        SAMPLE: begin
          if (cnt_reg == SAMP_LAST) begin
            // Leave tracking and present the MSB trial in one update.
            state_reg          <= COMPARE;
            samp_reg           <= 1'b0;
            ckl_reg            <= 1'b0;
            code_reg[idx_reg]  <= 1'b1;
`ifdef SAR_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        COMPARE: begin
          if (vop_s | von_s) begin
            // Both high is illegal and resolves the bit to 0.
            code_reg[idx_reg] <= vop_s & ~von_s;
            ckl_reg           <= 1'b1;
            state_reg         <= RESOLVE;
          end
`ifdef SAR_TIMEOUT_EN
          else if (to_cnt_reg == TO_LAST) begin
            code_reg[idx_reg] <= 1'b0;
            ckl_reg           <= 1'b1;
            to_flag_reg       <= 1'b1;
            state_reg         <= RESOLVE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
          end
`endif
        end
        RESOLVE: begin
          // Comparator must return to its reset state before the next trial.
          if (!vop_s && !von_s) begin
            if (idx_reg == '0) begin
              state_reg <= DONE;
              dout_reg  <= code_reg;
              eoc_reg   <= 1'b1;
            end else begin
              idx_reg                      <= idx_reg - IW'(1);
              code_reg[idx_reg - IW'(1)]   <= 1'b1;
              ckl_reg                      <= 1'b0;
              state_reg                    <= COMPARE;
`ifdef SAR_TIMEOUT_EN
              to_cnt_reg <= '0;
`endif
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.samp = samp_reg;
  assign bus.ckl  = ckl_reg;
  assign bus.dacp = code_reg;
  assign bus.dacn = ~code_reg;
  assign bus.dout = dout_reg;
  assign bus.eoc  = eoc_reg;
  assign bus.busy = (state_reg != IDLE);

`ifdef SAR_TIMEOUT_EN
  assign bus.to_flag = to_flag_reg;
`else
  assign bus.to_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic: comparator model on the front-end side, expected
// conversion results queued at SOC and checked by a monitor on EOC.
module tb_sar_logic;

  localparam int NBIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_logic_if #(.NBIT(NBIT)) bus ();

  sar_logic #(.NBIT(NBIT), .SAMPLE_CYC(4), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int eoc_cnt = 0;
  int silent_cycles = 0;
  int silent_bit = -1;
  int both_bit = -1;
  int both_hold = 0;
  logic [NBIT-1:0] vin = '0;
  logic [NBIT-1:0] exp_q[$];
  logic [NBIT-1:0] mon_inv;
  logic [NBIT-1:0] ones;

  function automatic int lowbit(logic [NBIT-1:0] v);
    for (int i = 0; i < NBIT; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic fail_wait(string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, want event", name);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_soc();
    bus.soc = 1'b1;
    tick(1);
    bus.soc = 1'b0;
  endtask

  task automatic wait_eoc(int start, string name);
    int n;
    n = 0;
    while (eoc_cnt == start && n < 600) begin
      tick(1);
      n++;
    end
    if (eoc_cnt == start) fail_wait(name);
  endtask

  task automatic convert(logic [NBIT-1:0] v, logic [NBIT-1:0] e, string name);
    int start;
    vin = v;
    exp_q.push_back(e);
    start = eoc_cnt;
    pulse_soc();
    wait_eoc(start, name);
    tick(2);
  endtask

  // Comparator model: decides once ckl has been low for a full cycle
  // (input is taken as mid-code, so vop when vin >= dac), releases once
  // ckl has been high for a full cycle plus an optional extra hold.
  initial begin : comparator
    int lo, hi, hold, t;
    bit decided;
    lo = 0; hi = 0; hold = 0; decided = 0;
    bus.vop = 1'b0;
    bus.von = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ckl === 1'b0) begin
        hi = 0;
        lo++;
        if (lo >= 2 && !decided) begin
          t = lowbit(bus.dacp);
          if (t != silent_bit) begin
            decided = 1;
            if (t == both_bit) begin
              bus.vop = 1'b1;
              bus.von = 1'b1;
              hold = both_hold;
            end else if (vin >= bus.dacp) begin
              bus.vop = 1'b1;
            end else begin
              bus.von = 1'b1;
            end
          end
        end
      end else begin
        lo = 0;
        hi++;
        if (hi >= 2 + hold) begin
          bus.vop = 1'b0;
          bus.von = 1'b0;
          decided = 0;
          hold = 0;
        end
      end
    end
  end

  // Monitor: DAC complement every cycle, result check on each EOC.
  initial begin : monitor
    logic [NBIT-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_inv = ~bus.dacp;
        check("dacn_inv", bus.dacn, mon_inv);
        if (silent_bit >= 0 && bus.ckl === 1'b0 && lowbit(bus.dacp) == silent_bit)
          silent_cycles++;
        if (bus.eoc === 1'b1) begin
          eoc_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL eoc_unexpected: got eoc dout=%h, want no eoc", bus.dout);
          end else begin
            e = exp_q.pop_front();
            check("dout", bus.dout, e);
            $display("conversion %0d: dout=%h expected=%h", eoc_cnt, bus.dout, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_samp"}, bus.samp, 0);
    check({tag, "_ckl"}, bus.ckl, 1);
    check({tag, "_dacp"}, bus.dacp, 0);
    check({tag, "_dacn"}, bus.dacn, ones);
    check({tag, "_dout"}, bus.dout, 0);
    check({tag, "_eoc"}, bus.eoc, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_to_flag"}, bus.to_flag, 0);
  endtask

  initial begin : stimulus
    int start, n;
    ones = '1;
    bus.soc = 1'b0;
    rst = 1'b1;
    tick(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick(2);

    // Basic conversion with BUSY/EOC framing.
    vin = 10'h2A5;
    exp_q.push_back(10'h2A5);
    start = eoc_cnt;
    pulse_soc();
    check("busy_after_soc", bus.busy, 1);
    check("samp_after_soc", bus.samp, 1);
    wait_eoc(start, "eoc_2a5");
    check("busy_at_eoc", bus.busy, 1);
    tick(1);
    check("eoc_width", bus.eoc, 0);
    check("busy_after_eoc", bus.busy, 0);
    check("dout_hold", bus.dout, 10'h2A5);
    check("to_flag_clear", bus.to_flag, 0);
    check("eoc_count_2a5", eoc_cnt - start, 1);

    // Full-scale extremes.
    convert(10'h3FF, 10'h3FF, "eoc_3ff");
    convert(10'h000, 10'h000, "eoc_000");

    // SOC during COMPARE of bit 7 is ignored.
    vin = 10'h155;
    exp_q.push_back(10'h155);
    start = eoc_cnt;
    pulse_soc();
    n = 0;
    while (!(bus.ckl === 1'b0 && lowbit(bus.dacp) == 7) && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) fail_wait("wait_bit7");
    pulse_soc();
    check("busy_soc_ignored", bus.busy, 1);
    wait_eoc(start, "eoc_155");
    tick(40);
    check("eoc_count_155", eoc_cnt - start, 1);

    // Illegal both-high decision on the MSB.
    both_bit = NBIT - 1;
    both_hold = 5;
    vin = 10'h3FF;
    exp_q.push_back(10'h1FF);
    start = eoc_cnt;
    pulse_soc();
    n = 0;
    while (!(bus.vop && bus.von && bus.ckl) && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) fail_wait("wait_both");
    n = 0;
    while (bus.vop && bus.von && n < 20) begin
      check("both_hold_ckl", bus.ckl, 1);
      check("both_hold_dacp", bus.dacp, 0);
      tick(1);
      n++;
    end
    wait_eoc(start, "eoc_both");
    both_bit = -1;
    both_hold = 0;
    tick(2);

    // Reset during RESOLVE of bit 3.
    vin = 10'h2A5;
    exp_q.push_back(10'h2A5);
    pulse_soc();
    n = 0;
    while (!(bus.ckl === 1'b0 && lowbit(bus.dacp) == 3) && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) fail_wait("wait_bit3");
    n = 0;
    while (bus.ckl !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) fail_wait("wait_resolve3");
    void'(exp_q.pop_back());
    start = eoc_cnt;
    rst = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick(20);
    check("no_eoc_after_rst", eoc_cnt - start, 0);
    convert(10'h2A5, 10'h2A5, "eoc_after_rst");

`ifdef SAR_TIMEOUT_EN
    // Comparator silent on bit 5.
    silent_bit = 5;
    silent_cycles = 0;
    vin = 10'h3FF;
    exp_q.push_back(10'h3DF);
    start = eoc_cnt;
    pulse_soc();
    wait_eoc(start, "eoc_timeout");
    silent_bit = -1;
    check("timeout_cycles", silent_cycles, 15);
    check("to_flag_set", bus.to_flag, 1);
    tick(5);
    check("to_flag_sticky", bus.to_flag, 1);
    exp_q.push_back(10'h3FF);
    start = eoc_cnt;
    pulse_soc();
    check("to_flag_cleared_by_soc", bus.to_flag, 0);
    wait_eoc(start, "eoc_after_timeout");
    tick(2);
`endif

    tick(5);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
